// File: rtl/ifm_fetch.sv
// ifm_fetch: walks a 5x5 IFM tile as nine 3x3 windows in a snake order.
// The first window is read in full (9 bytes). Each later step reads only the
// 3-byte row or column that enters the window. The packed bytes are then
// offered on a valid/ready step interface.
module ifm_fetch #(
    parameter int IMG_W     = 32,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         tile_row,
    input  logic [7:0]         tile_col,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_rd_data,
    output logic [2:0][31:0]   ifm_word,
    output logic [2:0]         ifm_mode,
    output logic               ifm_valid,
    input  logic               ifm_ready,
    output logic [3:0]         step_idx
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, PRESENT} state_t;

    localparam logic [2:0] MODE_ALL   = 3'b111;
    localparam logic [2:0] MODE_RIGHT = 3'b001;
    localparam logic [2:0] MODE_DOWN  = 3'b010;
    localparam logic [2:0] MODE_LEFT  = 3'b100;

    // Fixed step order: ALL, R, R, D, L, L, D, R, R
    function automatic logic [2:0] step_mode(input logic [3:0] s);
        case (s)
            4'd0:                      return MODE_ALL;
            4'd3, 4'd6:                return MODE_DOWN;
            4'd4, 4'd5:                return MODE_LEFT;
            default:                   return MODE_RIGHT;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          step_q, step_d;
    logic [3:0]          rd_cnt_q, rd_cnt_d;
    logic [3:0]          cap_cnt_q, cap_cnt_d;
    logic [7:0]          tile_row_q, tile_row_d;
    logic [7:0]          tile_col_q, tile_col_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_vld_q, rd_vld_d;
    logic [71:0]         shreg_q, shreg_d;
    logic                done_q, done_d;

    logic [2:0]          cur_mode;
    logic [3:0]          last_idx;
    logic [1:0]          off_r, off_c, dr, dc;
    logic [31:0]         row_abs, col_abs, addr_full;

    assign cur_mode = step_mode(step_q);
    assign last_idx = (step_q == 4'd0) ? 4'd8 : 4'd2;

    // Byte address of the read issued this cycle: window offset plus the byte's position in the step
    always_comb begin
        off_r = 2'd0;
        off_c = 2'd0;
        dr    = 2'd0;
        dc    = 2'd0;
        case (step_q)
            4'd0: begin off_r = 2'd0; off_c = 2'd0; end
            4'd1: begin off_r = 2'd0; off_c = 2'd1; end
            4'd2: begin off_r = 2'd0; off_c = 2'd2; end
            4'd3: begin off_r = 2'd1; off_c = 2'd2; end
            4'd4: begin off_r = 2'd1; off_c = 2'd1; end
            4'd5: begin off_r = 2'd1; off_c = 2'd0; end
            4'd6: begin off_r = 2'd2; off_c = 2'd0; end
            4'd7: begin off_r = 2'd2; off_c = 2'd1; end
            default: begin off_r = 2'd2; off_c = 2'd2; end
        endcase
        case (cur_mode)
            MODE_ALL: begin
                case (rd_cnt_q)
                    4'd0, 4'd1, 4'd2: dr = 2'd0;
                    4'd3, 4'd4, 4'd5: dr = 2'd1;
                    default:          dr = 2'd2;
                endcase
                case (rd_cnt_q)
                    4'd0, 4'd3, 4'd6: dc = 2'd0;
                    4'd1, 4'd4, 4'd7: dc = 2'd1;
                    default:          dc = 2'd2;
                endcase
            end
            MODE_RIGHT: begin dr = rd_cnt_q[1:0]; dc = 2'd2; end
            MODE_DOWN:  begin dr = 2'd2; dc = rd_cnt_q[1:0]; end
            default:    begin dr = rd_cnt_q[1:0]; dc = 2'd0; end
        endcase
        row_abs   = 32'(tile_row_q) + 32'(off_r) + 32'(dr);
        col_abs   = 32'(tile_col_q) + 32'(off_c) + 32'(dc);
        addr_full = 32'(BASE_ADDR) + row_abs * 32'(IMG_W) + col_abs;
    end

    // Next-state logic. Reads issue back to back. A byte is captured one
    // cycle after its strobe leaves the block.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        rd_cnt_d   = rd_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        tile_row_d = tile_row_q;
        tile_col_d = tile_col_q;
        rd_en_d    = 1'b0;
        addr_d     = addr_q;
        rd_vld_d   = rd_en_q;
        shreg_d    = shreg_q;
        done_d     = 1'b0;

        if (rd_vld_q) begin
            shreg_d   = {shreg_q[63:0], mem_rd_data};
            cap_cnt_d = cap_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    tile_row_d = tile_row;
                    tile_col_d = tile_col;
                    step_d     = 4'd0;
                    rd_cnt_d   = 4'd0;
                    cap_cnt_d  = 4'd0;
                    state_d    = READ;
                end
            end
            READ: begin
                rd_en_d  = 1'b1;
                addr_d   = addr_full[ADDR_W-1:0];
                rd_cnt_d = rd_cnt_q + 4'd1;
                if (rd_cnt_q == last_idx) state_d = WAIT;
            end
            WAIT: begin
                if (rd_vld_q && cap_cnt_q == last_idx) state_d = PRESENT;
            end
            default: begin
                if (ifm_ready) begin
                    if (step_q == 4'd8) begin
                        step_d  = 4'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        step_d    = step_q + 4'd1;
                        rd_cnt_d  = 4'd0;
                        cap_cnt_d = 4'd0;
                        state_d   = READ;
                    end
                end
            end
        endcase
    end

    // State registers. Reset also clears the read pipeline, so data still in flight is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= 4'd0;
            rd_cnt_q   <= 4'd0;
            cap_cnt_q  <= 4'd0;
            tile_row_q <= 8'd0;
            tile_col_q <= 8'd0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            rd_vld_q   <= 1'b0;
            shreg_q    <= 72'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            rd_cnt_q   <= rd_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            tile_row_q <= tile_row_d;
            tile_col_q <= tile_col_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            rd_vld_q   <= rd_vld_d;
            shreg_q    <= shreg_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign ifm_valid = (state_q == PRESENT);
    assign ifm_mode  = busy ? cur_mode : 3'b000;
    assign step_idx  = step_q;

    // Output packing. The newest bytes sit at the bottom of the shift register, oldest first.
    always_comb begin
        ifm_word = '0;
        if (state_q == PRESENT) begin
            case (cur_mode)
                MODE_ALL: begin
                    ifm_word[0] = {8'h00, shreg_q[71:48]};
                    ifm_word[1] = {8'h00, shreg_q[47:24]};
                    ifm_word[2] = {8'h00, shreg_q[23:0]};
                end
                MODE_RIGHT: ifm_word[0] = {8'h00, shreg_q[23:0]};
                MODE_DOWN:  ifm_word[1] = {8'h00, shreg_q[23:0]};
                default:    ifm_word[2] = {8'h00, shreg_q[23:0]};
            endcase
        end
    end

endmodule
